// File: rtl/wired_iq_pkg.sv
// rtl/wired_iq_pkg.sv - shared types, widths and tag-match helper for the SEL issue queue
`timescale 1ns/1ps
package wired_iq_pkg;

  localparam int IQ_DEPTH     = 4;
  localparam int IQ_WKUP_CNT  = 2;
  localparam int IQ_TAG_W     = 6;
  localparam int IQ_PAYLOAD_W = 32;
  localparam int IQ_DATA_W    = 32;
  localparam int IQ_SRC_W     = (IQ_WKUP_CNT > 1) ? $clog2(IQ_WKUP_CNT) : 1;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    CAPT = 2'd1,
    RDY  = 2'd2
  } iq_oprd_state_e;

  typedef struct packed {
    iq_oprd_state_e        state;
    logic [IQ_TAG_W-1:0]   tag;
    logic [IQ_SRC_W-1:0]   src;
    logic [IQ_DATA_W-1:0]  data;
  } iq_oprd_t;

  typedef struct packed {
    logic                    valid;
    logic [IQ_PAYLOAD_W-1:0] payload;
    iq_oprd_t [1:0]          oprd;
  } iq_entry_t;

  typedef struct packed {
    logic                hit;
    logic [IQ_SRC_W-1:0] src;
  } iq_match_t;

  // Compare one tag against every broadcast; the lowest matching source index wins.
  function automatic iq_match_t iq_tag_match(
    input logic [IQ_TAG_W-1:0]                  tag,
    input logic [IQ_WKUP_CNT-1:0]               wkup_valid,
    input logic [IQ_WKUP_CNT-1:0][IQ_TAG_W-1:0] wkup_tag
  );
    iq_match_t m;
    m = '0;
    for (int s = IQ_WKUP_CNT - 1; s >= 0; s--) begin
      if (wkup_valid[s] && (wkup_tag[s] == tag)) begin
        m.hit = 1'b1;
        m.src = IQ_SRC_W'(s);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wired_iq_oprd.sv
// rtl/wired_iq_oprd.sv - per-operand wakeup match, state advance and select-side outputs
`timescale 1ns/1ps
module wired_iq_oprd
  import wired_iq_pkg::*;
(
  input  iq_oprd_t                                oprd_i,
  input  logic [IQ_WKUP_CNT-1:0]                  wkup_valid_i,
  input  logic [IQ_WKUP_CNT-1:0][IQ_TAG_W-1:0]    wkup_tag_i,
  input  logic [IQ_WKUP_CNT-1:0][IQ_DATA_W-1:0]   wkup_data_i,
  output logic                                    eligible_o,
  output logic [IQ_WKUP_CNT-1:0]                  wkup_src_o,
  output logic [IQ_DATA_W-1:0]                    data_o,
  output iq_oprd_t                                oprd_o
);

  iq_match_t             match;
  logic [IQ_DATA_W-1:0]  capt_data;
  logic [IQ_WKUP_CNT-1:0] match_onehot;

  assign match     = iq_tag_match(oprd_i.tag, wkup_valid_i, wkup_tag_i);
  assign capt_data = wkup_data_i[oprd_i.src];

  // One-hot of the winning broadcast source, handed downstream so FU1 forwards its data.
  always_comb begin
    match_onehot = '0;
    match_onehot[match.src] = 1'b1;
  end

  // Next operand state plus what this operand contributes if its entry is selected.
  always_comb begin
    oprd_o     = oprd_i;
    eligible_o = 1'b0;
    wkup_src_o = '0;
    data_o     = '0;
    case (oprd_i.state)
      WAIT: begin
        if (match.hit) begin
          oprd_o.state = CAPT;
          oprd_o.src   = match.src;
          eligible_o   = 1'b1;
          wkup_src_o   = match_onehot;
        end
      end
      CAPT: begin
        oprd_o.state = RDY;
        oprd_o.data  = capt_data;
        eligible_o   = 1'b1;
        data_o       = capt_data;
      end
      RDY: begin
        eligible_o = 1'b1;
        data_o     = oprd_i.data;
      end
      default: begin
        oprd_o = oprd_i;
      end
    endcase
  end

endmodule

// File: rtl/wired_iq_sel.sv
// rtl/wired_iq_sel.sv - age-ordered collapsing issue queue feeding the FU1 wakeup-data register
`timescale 1ns/1ps
module wired_iq_sel
  import wired_iq_pkg::*;
#(
  parameter int DEPTH          = IQ_DEPTH,
  parameter int WAKEUP_SRC_CNT = IQ_WKUP_CNT,
  parameter int TAG_W          = IQ_TAG_W,
  parameter int PAYLOAD_W      = IQ_PAYLOAD_W
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       flush_i,
  input  logic                                       p_valid_i,
  output logic                                       p_ready_o,
  input  logic [PAYLOAD_W-1:0]                       p_payload_i,
  input  logic [1:0]                                 p_rdy_i,
  input  logic [1:0][TAG_W-1:0]                      p_tag_i,
  input  logic [1:0][IQ_DATA_W-1:0]                  p_data_i,
  input  logic [WAKEUP_SRC_CNT-1:0]                  wkup_valid_i,
  input  logic [WAKEUP_SRC_CNT-1:0][TAG_W-1:0]       wkup_tag_i,
  input  logic [WAKEUP_SRC_CNT-1:0][IQ_DATA_W-1:0]   wkup_data_i,
  output logic                                       issue_valid_o,
  input  logic                                       issue_ready_i,
  output logic [PAYLOAD_W-1:0]                       issue_payload_o,
  output logic [1:0][WAKEUP_SRC_CNT-1:0]             issue_wkup_src_o,
  output logic [1:0][IQ_DATA_W-1:0]                  issue_data_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  iq_entry_t                  entry_q [DEPTH];
  iq_entry_t                  entry_d [DEPTH];
  iq_entry_t                  upd     [DEPTH+1];
  logic [CNT_W-1:0]           count_q;
  logic [CNT_W-1:0]           count_d;

  iq_oprd_t                   oprd_nxt  [DEPTH][2];
  logic                       oprd_elig [DEPTH][2];
  logic [WAKEUP_SRC_CNT-1:0]  oprd_src  [DEPTH][2];
  logic [IQ_DATA_W-1:0]       oprd_data [DEPTH][2];

  logic [DEPTH-1:0]           elig;
  logic [DEPTH-1:0]           grant;
  logic [DEPTH-1:0]           shift;
  logic                       sel_valid;
  logic                       fire;
  logic                       enq;
  logic [CNT_W-1:0]           wr_idx;
  iq_entry_t                  new_entry;
  iq_match_t                  enq_match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    for (genvar j = 0; j < 2; j++) begin : g_oprd
      wired_iq_oprd u_oprd (
        .oprd_i       (entry_q[i].oprd[j]),
        .wkup_valid_i (wkup_valid_i),
        .wkup_tag_i   (wkup_tag_i),
        .wkup_data_i  (wkup_data_i),
        .eligible_o   (oprd_elig[i][j]),
        .wkup_src_o   (oprd_src[i][j]),
        .data_o       (oprd_data[i][j]),
        .oprd_o       (oprd_nxt[i][j])
      );
    end
    assign elig[i] = entry_q[i].valid && oprd_elig[i][0] && oprd_elig[i][1];
  end

  // Oldest-ready select: grant the lowest eligible slot; shift marks it and every slot above.
  always_comb begin
    grant     = '0;
    shift     = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !sel_valid) begin
        grant[i] = 1'b1;
      end
      sel_valid = sel_valid | elig[i];
      shift[i]  = sel_valid;
    end
  end

  assign issue_valid_o = rst_n && sel_valid;
  assign fire          = issue_valid_o && issue_ready_i;
  assign p_ready_o     = rst_n && (count_q < CNT_W'(DEPTH));
  assign enq           = p_valid_i && p_ready_o;
  assign wr_idx        = count_q - CNT_W'(fire);

  // Build the incoming entry; operands already woken this cycle skip straight to CAPT.
  always_comb begin
    new_entry         = '0;
    enq_match         = '0;
    new_entry.valid   = 1'b1;
    new_entry.payload = p_payload_i;
    for (int j = 0; j < 2; j++) begin
      enq_match = iq_tag_match(p_tag_i[j], wkup_valid_i, wkup_tag_i);
      new_entry.oprd[j].tag = p_tag_i[j];
      if (p_rdy_i[j]) begin
        new_entry.oprd[j].state = RDY;
        new_entry.oprd[j].data  = p_data_i[j];
      end else if (enq_match.hit) begin
        new_entry.oprd[j].state = CAPT;
        new_entry.oprd[j].src   = enq_match.src;
      end else begin
        new_entry.oprd[j].state = WAIT;
      end
    end
  end

  // Apply this cycle's operand updates to every live entry; the extra top slot feeds an empty shift-in.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      upd[i] = '0;
      if (entry_q[i].valid) begin
        upd[i]         = entry_q[i];
        upd[i].oprd[0] = oprd_nxt[i][0];
        upd[i].oprd[1] = oprd_nxt[i][1];
      end
    end
    upd[DEPTH] = '0;
  end

  // Collapse over the fired slot, then drop the new entry into the first free slot.
  always_comb begin
    count_d = count_q - CNT_W'(fire) + CNT_W'(enq);
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = (fire && shift[i]) ? upd[i+1] : upd[i];
      if (enq && (wr_idx == CNT_W'(i))) begin
        entry_d[i] = new_entry;
      end
    end
  end

  // Queue state register; flush empties the queue regardless of enqueue or fire.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Issue mux over the one-hot grant; everything reads zero when nothing is granted.
  always_comb begin
    issue_payload_o  = '0;
    issue_wkup_src_o = '0;
    issue_data_o     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i] && rst_n) begin
        issue_payload_o = entry_q[i].payload;
        for (int j = 0; j < 2; j++) begin
          issue_wkup_src_o[j] = oprd_src[i][j];
          issue_data_o[j]     = oprd_data[i][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_wired_iq_sel.sv
// tb/tb_wired_iq_sel.sv - directed self-checking bench for wired_iq_sel
`timescale 1ns/1ps
module tb_wired_iq_sel;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush_i;
  logic              p_valid_i;
  logic              p_ready_o;
  logic [31:0]       p_payload_i;
  logic [1:0]        p_rdy_i;
  logic [1:0][5:0]   p_tag_i;
  logic [1:0][31:0]  p_data_i;
  logic [1:0]        wkup_valid_i;
  logic [1:0][5:0]   wkup_tag_i;
  logic [1:0][31:0]  wkup_data_i;
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic [31:0]       issue_payload_o;
  logic [1:0][1:0]   issue_wkup_src_o;
  logic [1:0][31:0]  issue_data_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wired_iq_sel dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .p_valid_i        (p_valid_i),
    .p_ready_o        (p_ready_o),
    .p_payload_i      (p_payload_i),
    .p_rdy_i          (p_rdy_i),
    .p_tag_i          (p_tag_i),
    .p_data_i         (p_data_i),
    .wkup_valid_i     (wkup_valid_i),
    .wkup_tag_i       (wkup_tag_i),
    .wkup_data_i      (wkup_data_i),
    .issue_valid_o    (issue_valid_o),
    .issue_ready_i    (issue_ready_i),
    .issue_payload_o  (issue_payload_o),
    .issue_wkup_src_o (issue_wkup_src_o),
    .issue_data_o     (issue_data_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    p_valid_i     = 1'b0;
    p_payload_i   = '0;
    p_rdy_i       = '0;
    p_tag_i       = '0;
    p_data_i      = '0;
    wkup_valid_i  = '0;
    wkup_tag_i    = '0;
    wkup_data_i   = '0;
    issue_ready_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pl, input logic [1:0] rdy,
                      input logic [5:0] t0, input logic [5:0] t1,
                      input logic [31:0] d0, input logic [31:0] d1);
    p_valid_i   = 1'b1;
    p_payload_i = pl;
    p_rdy_i     = rdy;
    p_tag_i[0]  = t0;
    p_tag_i[1]  = t1;
    p_data_i[0] = d0;
    p_data_i[1] = d1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", issue_valid_o, 0);
    chk("rst_pready", p_ready_o, 0);
    chk("rst_payload", issue_payload_o, 0);
    rst_n = 1'b1;
    tick();

    // A: both operands ready at enqueue
    idle(); push(32'hA, 2'b11, 0, 0, 32'h11, 32'h22); #1;
    chk("post_rst_pready", p_ready_o, 1);
    chk("a_no_same_cycle", issue_valid_o, 0);
    tick();
    idle(); #1;
    chk("a_valid", issue_valid_o, 1);
    chk("a_payload", issue_payload_o, 32'hA);
    chk("a_data0", issue_data_o[0], 32'h11);
    chk("a_data1", issue_data_o[1], 32'h22);
    chk("a_src", issue_wkup_src_o, 0);
    issue_ready_i = 1'b1;
    tick();
    idle(); #1;
    chk("a_gone", issue_valid_o, 0);

    // B: back-to-back wakeup issue from source 1
    push(32'hB, 2'b10, 5, 0, 0, 32'h33);
    tick();
    idle(); #1;
    chk("b_wait", issue_valid_o, 0);
    wkup_valid_i = 2'b10; wkup_tag_i[1] = 6'd5; issue_ready_i = 1'b1; #1;
    chk("b_valid", issue_valid_o, 1);
    chk("b_payload", issue_payload_o, 32'hB);
    chk("b_src0", issue_wkup_src_o[0], 2'b10);
    chk("b_data0", issue_data_o[0], 0);
    chk("b_data1", issue_data_o[1], 32'h33);
    chk("b_src1", issue_wkup_src_o[1], 0);
    tick();
    idle(); #1;
    chk("b_gone", issue_valid_o, 0);

    // C: stalled wakeup picks data up through CAPT, then holds it
    push(32'hC, 2'b10, 5, 0, 0, 32'h44);
    tick();
    idle(); wkup_valid_i = 2'b10; wkup_tag_i[1] = 6'd5; #1;
    chk("c_t_src0", issue_wkup_src_o[0], 2'b10);
    tick();
    idle(); wkup_data_i[1] = 32'hDEAD; #1;
    chk("c_t1_valid", issue_valid_o, 1);
    chk("c_t1_data0", issue_data_o[0], 32'hDEAD);
    chk("c_t1_src0", issue_wkup_src_o[0], 0);
    tick();
    idle(); wkup_data_i[1] = 32'hBEEF; #1;
    chk("c_hold_data0", issue_data_o[0], 32'hDEAD);
    chk("c_hold_data1", issue_data_o[1], 32'h44);
    issue_ready_i = 1'b1;
    tick();

    // D: fill, fire the middle entry, collapse
    idle(); push(32'h10, 2'b00, 7, 7, 0, 0); tick();
    idle(); push(32'h11, 2'b11, 0, 0, 32'h101, 32'h111); tick();
    idle(); push(32'h12, 2'b11, 0, 0, 32'h102, 32'h112); tick();
    idle(); push(32'h13, 2'b00, 9, 9, 0, 0); tick();
    idle(); #1;
    chk("d_full_pready", p_ready_o, 0);
    chk("d_sel_slot1", issue_payload_o, 32'h11);
    push(32'h99, 2'b11, 0, 0, 1, 2); issue_ready_i = 1'b1;
    tick();
    idle(); #1;
    chk("d_pready_back", p_ready_o, 1);
    chk("d_next_oldest", issue_payload_o, 32'h12);
    chk("d_next_data0", issue_data_o[0], 32'h102);
    issue_ready_i = 1'b1;
    tick();
    idle(); #1;
    chk("d_none_ready", issue_valid_o, 0);
    wkup_valid_i = 2'b01; wkup_tag_i[0] = 6'd9; #1;
    chk("d3_wake_payload", issue_payload_o, 32'h13);
    chk("d3_wake_src0", issue_wkup_src_o[0], 2'b01);
    chk("d3_wake_src1", issue_wkup_src_o[1], 2'b01);
    tick();
    idle(); wkup_valid_i = 2'b10; wkup_tag_i[1] = 6'd7; wkup_data_i[0] = 32'h909; #1;
    chk("d0_oldest_wins", issue_payload_o, 32'h10);
    chk("d0_src0", issue_wkup_src_o[0], 2'b10);
    issue_ready_i = 1'b1;
    tick();
    idle(); #1;
    chk("d3_shift_valid", issue_valid_o, 1);
    chk("d3_shift_payload", issue_payload_o, 32'h13);
    chk("d3_shift_data0", issue_data_o[0], 32'h909);
    chk("d3_shift_data1", issue_data_o[1], 32'h909);
    chk("d3_shift_src", issue_wkup_src_o, 0);

    // Flush with enqueue and fire in the same cycle
    flush_i = 1'b1; push(32'h55, 2'b11, 0, 0, 5, 6); issue_ready_i = 1'b1; #1;
    chk("flush_cycle_valid", issue_valid_o, 1);
    chk("flush_cycle_payload", issue_payload_o, 32'h13);
    tick();
    idle(); #1;
    chk("flush_empty", issue_valid_o, 0);
    chk("flush_pready", p_ready_o, 1);

    // Two sources on one operand: lowest index wins
    push(32'h70, 2'b10, 3, 0, 0, 32'h77);
    tick();
    idle(); wkup_valid_i = 2'b11; wkup_tag_i[0] = 6'd3; wkup_tag_i[1] = 6'd3; #1;
    chk("dual_src0", issue_wkup_src_o[0], 2'b01);
    issue_ready_i = 1'b1;
    tick();

    // Enqueue during a matching broadcast starts in CAPT
    idle(); push(32'h80, 2'b10, 4, 0, 0, 32'h88);
    wkup_valid_i = 2'b10; wkup_tag_i[1] = 6'd4; #1;
    chk("enq_capt_no_issue", issue_valid_o, 0);
    tick();
    idle(); wkup_data_i[1] = 32'h4444; #1;
    chk("enq_capt_valid", issue_valid_o, 1);
    chk("enq_capt_data0", issue_data_o[0], 32'h4444);
    chk("enq_capt_src0", issue_wkup_src_o[0], 0);
    issue_ready_i = 1'b1;
    tick();

    // Reset mid-stream with three entries held
    idle(); push(32'h60, 2'b11, 0, 0, 1, 1); tick();
    idle(); push(32'h61, 2'b11, 0, 0, 2, 2); tick();
    idle(); push(32'h62, 2'b11, 0, 0, 3, 3); tick();
    idle(); #1;
    chk("e_head", issue_payload_o, 32'h60);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", issue_valid_o, 0);
    chk("mid_rst_pready", p_ready_o, 0);
    chk("mid_rst_data", issue_data_o, 0);
    rst_n = 1'b1; #1;
    chk("rel_pready", p_ready_o, 1);
    tick();
    chk("rel_empty", issue_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
